// File: rtl/instr_fetch.sv
// Instruction-fetch sequencer: owns the PC, reads synchronous memory, and hands each word to the cpu.
// Latency: FETCH to ir_load is MEM_LATENCY+2 cycles; the cpu handshake (s / w) then gates the next fetch.
// Backpressure: stalls in START until the cpu drops w, and in EXEC until it raises w again; HALT is terminal.
module instr_fetch #(
    parameter int                    data_width  = 16,
    parameter int                    addr_width  = 8,
    parameter int                    MEM_LATENCY = 1,
    parameter logic [addr_width-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  cpu_w,
    input  logic                  branch_take,
    input  logic [addr_width-1:0] branch_target,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_rd,
    output logic [data_width-1:0] ir_out,
    output logic                  ir_load,
    output logic                  cpu_s,
    output logic [addr_width-1:0] pc_out,
    output logic                  halted
);

    // Memory latency of 1..7 fits in a 3-bit down-counter.
    localparam logic [2:0] LAT_RELOAD = 3'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_MWAIT  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_START  = 3'd5,
        ST_EXEC   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    state_t                  state_q;
    logic [addr_width-1:0]   pc_q;
    logic [data_width-1:0]   ir_q;
    logic [2:0]              lat_cnt_q;
    logic                    mem_rd_q;
    logic                    ir_load_q;
    logic                    cpu_s_q;
    logic                    halted_q;

    logic [addr_width-1:0]   pc_inc_d;
    logic                    is_halt_d;

    // Sequential PC (wraps naturally at 2^addr_width) and HALT opcode decode of the held word.
    always_comb begin
        pc_inc_d  = pc_q + 1'b1;
        is_halt_d = (ir_q[data_width-1 -: 3] == 3'b111);
    end

    // Sequencer FSM; every output is a register so strobes are glitch-free toward memory and cpu.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            lat_cnt_q <= '0;
            mem_rd_q  <= 1'b0;
            ir_load_q <= 1'b0;
            cpu_s_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them below.
            mem_rd_q  <= 1'b0;
            ir_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q  <= ST_FETCH;
                        mem_rd_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    lat_cnt_q <= LAT_RELOAD;
                    state_q   <= ST_MWAIT;
                end
                ST_MWAIT: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q <= ST_LOAD;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                ST_LOAD: begin
                    // The PC advances as UPDATE begins so the cpu sees PC+1 alongside ir_load.
                    ir_q      <= mem_rdata;
                    pc_q      <= pc_inc_d;
                    ir_load_q <= 1'b1;
                    state_q   <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (is_halt_d) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        cpu_s_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    // cpu has left its wait state: it owns the instruction now.
                    if (!cpu_w) begin
                        cpu_s_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // cpu back in wait: commit any redirect, then fetch or park.
                    if (cpu_w) begin
                        if (branch_take) begin
                            pc_q <= branch_target;
                        end
                        if (run) begin
                            state_q  <= ST_FETCH;
                            mem_rd_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = pc_q;
    assign pc_out   = pc_q;
    assign mem_rd   = mem_rd_q;
    assign ir_out   = ir_q;
    assign ir_load  = ir_load_q;
    assign cpu_s    = cpu_s_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-1 instance running a short program with branches,
// PC wrap and HALT against a cpu model, and a latency-3 instance reset in the middle of MWAIT.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- latency-1 instance ----------------
    logic        reset, run, cpu_w, branch_take, mem_rd, ir_load, cpu_s, halted;
    logic [15:0] mem_rdata, ir_out;
    logic [7:0]  branch_target, mem_addr, pc_out;
    logic [15:0] mem [256];

    instr_fetch #(.data_width(16), .addr_width(8), .MEM_LATENCY(1), .RESET_PC(8'h10)) u_dut (
        .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata), .cpu_w(cpu_w),
        .branch_take(branch_take), .branch_target(branch_target), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .ir_out(ir_out), .ir_load(ir_load), .cpu_s(cpu_s),
        .pc_out(pc_out), .halted(halted)
    );

    // Synchronous memory: data appears one cycle after the read strobe and holds.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // cpu model: drops w one cycle after seeing s, raises it 4 cycles later.
    // Redirects: 0x1111 -> 0x40, 0x2222 -> 0xFF; a bogus branch is waved during START of 0x1111.
    initial begin
        cpu_w = 1'b1; branch_take = 1'b0; branch_target = 8'h00;
        forever begin
            @(negedge clk);
            if (cpu_s && cpu_w) begin
                if (ir_out == 16'h1111) begin
                    branch_take = 1'b1; branch_target = 8'h77;
                end
                @(negedge clk);
                cpu_w = 1'b0; branch_take = 1'b0;
                repeat (4) @(negedge clk);
                cpu_w = 1'b1;
                if (ir_out == 16'h1111) begin
                    branch_take = 1'b1; branch_target = 8'h40;
                end else if (ir_out == 16'h2222) begin
                    branch_take = 1'b1; branch_target = 8'hFF;
                end
                @(negedge clk);
                branch_take = 1'b0;
            end
        end
    end

    // Event recorder for the latency-1 instance.
    logic [7:0]  fetch_q [$];
    logic [23:0] ld_q [$];
    int          first_rd = -1, first_ld = -1, s_pulses = 0, overlap = 0;
    logic        s_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd) begin
                fetch_q.push_back(mem_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (ir_load) begin
                ld_q.push_back({pc_out, ir_out});
                if (first_ld < 0) first_ld = cyc;
            end
            if (mem_rd && ir_load) overlap++;
            if (cpu_s && !s_prev) s_pulses++;
            s_prev = cpu_s;
        end
    end

    // ---------------- latency-3 instance ----------------
    logic        reset3, run3, cpu_w3, mem_rd3, ir_load3, cpu_s3, halted3;
    logic [15:0] ir_out3;
    logic [7:0]  mem_addr3, pc_out3;

    // Minimal cpu: accepts immediately, finishes the cycle after.
    assign cpu_w3 = ~cpu_s3;

    instr_fetch #(.data_width(16), .addr_width(8), .MEM_LATENCY(3), .RESET_PC(8'h10)) u_dut3 (
        .clk(clk), .reset(reset3), .run(run3), .mem_rdata(16'h0ABC), .cpu_w(cpu_w3),
        .branch_take(1'b0), .branch_target(8'h00), .mem_addr(mem_addr3),
        .mem_rd(mem_rd3), .ir_out(ir_out3), .ir_load(ir_load3), .cpu_s(cpu_s3),
        .pc_out(pc_out3), .halted(halted3)
    );

    logic [7:0]  exp_fetch [6] = '{8'h10, 8'h40, 8'hFF, 8'h00, 8'h01, 8'h02};
    logic [23:0] exp_ld    [6] = '{{8'h11, 16'h1111}, {8'h41, 16'h2222}, {8'h00, 16'h3333},
                                   {8'h01, 16'h1234}, {8'h02, 16'h5678}, {8'h03, 16'hE000}};

    initial begin
        int n, t0, nf, nl;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h1111;
        mem[8'h40] = 16'h2222;
        mem[8'hFF] = 16'h3333;
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'h5678;
        mem[8'h02] = 16'hE000;
        mem[8'h77] = 16'h7777;
        reset = 1'b1; run = 1'b0; reset3 = 1'b1; run3 = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", mem_addr, 8'h10);
        chk("rst_pc_out", pc_out, 8'h10);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_ir_load", ir_load, 1'b0);
        chk("rst_cpu_s", cpu_s, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ir_out", ir_out, 16'h0);

        // Program run: branch, ignored branch, wrap, sequential, HALT.
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 600 && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1'b1);
        chk("halt_pc", pc_out, 8'h03);
        repeat (20) @(negedge clk);
        chk("halt_pc_frozen", pc_out, 8'h03);
        chk("halt_sticky", halted, 1'b1);
        chk("halt_cpu_s", cpu_s, 1'b0);

        chk("fetch_latency", 32'(first_ld - first_rd), 32'd3);
        nf = fetch_q.size();
        nl = ld_q.size();
        chk("fetch_count", 32'(nf), 32'd6);
        chk("load_count", 32'(nl), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fetch_addr%0d", i), (i < nf) ? 32'(fetch_q[i]) : 32'hFFFF_FFFF, 32'(exp_fetch[i]));
            chk($sformatf("load%0d_pc_ir", i), (i < nl) ? 32'(ld_q[i]) : 32'hFFFF_FFFF, 32'(exp_ld[i]));
        end
        chk("s_pulses", 32'(s_pulses), 32'd5);
        chk("rd_ld_overlap", 32'(overlap), 32'd0);

        // Latency-3 instance: one full instruction, then reset inside the second MWAIT.
        @(negedge clk);
        reset3 = 1'b0; run3 = 1'b1;
        n = 0; while (!mem_rd3 && n < 30) begin @(negedge clk); n++; end
        chk("l3_rd1", mem_rd3, 1'b1);
        chk("l3_addr1", mem_addr3, 8'h10);
        t0 = cyc;
        n = 0; while (!ir_load3 && n < 30) begin @(negedge clk); n++; end
        chk("l3_ld1", ir_load3, 1'b1);
        chk("l3_latency1", 32'(cyc - t0), 32'd5);
        chk("l3_ir1", ir_out3, 16'h0ABC);
        chk("l3_pc1", pc_out3, 8'h11);
        n = 0; while (!mem_rd3 && n < 30) begin @(negedge clk); n++; end
        chk("l3_addr2", mem_addr3, 8'h11);
        @(negedge clk);
        reset3 = 1'b1;
        #1;
        chk("l3_rst_mem_addr", mem_addr3, 8'h10);
        chk("l3_rst_pc_out", pc_out3, 8'h10);
        chk("l3_rst_ir_out", ir_out3, 16'h0);
        chk("l3_rst_strobes", {mem_rd3, ir_load3, cpu_s3, halted3}, 4'b0000);
        @(negedge clk);
        reset3 = 1'b0;
        n = 0; while (!mem_rd3 && n < 30) begin @(negedge clk); n++; end
        chk("l3_refetch_addr", mem_addr3, 8'h10);
        t0 = cyc;
        n = 0; while (!ir_load3 && n < 30) begin @(negedge clk); n++; end
        chk("l3_latency2", 32'(cyc - t0), 32'd5);
        chk("l3_ir2", ir_out3, 16'h0ABC);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
